// File: rtl/bin2gray_stream.sv
// Streaming binary-to-Gray encoder with a DEPTH-entry first-word-fall-through FIFO.
// Optional feature macro: GRAY_PARITY_EN adds port gray_par (stored parity per entry).
module bin2gray_stream #(
    parameter int N     = 4,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  bin_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  gray_out,
`ifdef GRAY_PARITY_EN
    output logic          gray_par,
`endif
    output logic [AW:0]   count
);

`ifdef GRAY_PARITY_EN
    localparam int MW = N + 1;
`else
    localparam int MW = N;
`endif

    localparam logic [AW:0] CNT_FULL     = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_NEAR_FULL = (AW + 1)'(DEPTH - 1);
    localparam logic [AW:0] CNT_ONE      = (AW + 1)'(1);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } region_t;

    region_t        r_region;
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic [MW-1:0]  r_mem [DEPTH];

    logic           w_push;
    logic           w_pop;
    logic [N-1:0]   w_gray;
    logic [MW-1:0]  w_entry;

    // Handshake flags come from the registered region only, so a pop never
    // opens in_ready in the same cycle and an empty FIFO never forwards bin_in.
    assign in_ready  = (r_region != ST_FULL);
    assign out_valid = (r_region != ST_EMPTY);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign w_gray = bin_in ^ (bin_in >> 1);
`ifdef GRAY_PARITY_EN
    assign w_entry  = {^w_gray, w_gray};
    assign gray_par = out_valid ? r_mem[r_rd_ptr][N] : 1'b0;
`else
    assign w_entry = w_gray;
`endif

    assign gray_out = out_valid ? r_mem[r_rd_ptr][N-1:0] : '0;
    assign count    = r_count;

    // NOTE: storage has no reset; entries are only visible through out_valid,
    // which is cleared by rst, so stale contents can never reach the output.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every branch reads
    // the pre-edge count and pointers, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_region <= ST_EMPTY;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10: begin
                    r_count  <= r_count + 1'b1;
                    r_region <= (r_count == CNT_NEAR_FULL) ? ST_FULL : ST_PARTIAL;
                end
                2'b01: begin
                    r_count  <= r_count - 1'b1;
                    r_region <= (r_count == CNT_ONE) ? ST_EMPTY : ST_PARTIAL;
                end
                default: begin
                    r_count  <= r_count;
                    r_region <= r_region;
                end
            endcase
        end
    end

    logic w_unused_full;
    assign w_unused_full = (r_count == CNT_FULL);

endmodule
